sodor_imem_responder: RTL and testbench

- Instruction-memory responder for the Sodor 5-stage core: the far end of the core's imem request port (io_imem_req_* out of CoreTop).
- Holds a small writable program store and answers fetch requests with a fixed, configurable latency.
- Returns responses in order, with response-side backpressure and a flush for pipeline redirects.
- Replaces the combinational program-array lookup in verification benches with a sequential, latency-accurate memory.

---
 rtl/sodor_imem_responder.sv | 167 ++++++++++++++++
 tb/tb_sodor_imem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sodor_imem_responder
// Desc     : Latency-accurate instruction memory answering Sodor imem fetches
//            in order, with response backpressure and pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module sodor_imem_responder #(
   parameter int          DEPTH           = 16,
   parameter int          LATENCY         = 1,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [31:0] NOP_INST        = 32'h00000013
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_imem_req_valid,
   input  logic [31:0]              io_imem_req_bits_addr,
   output logic                     io_imem_req_ready,
   output logic                     io_imem_resp_valid,
   output logic [31:0]              io_imem_resp_bits_data,
   output logic                     io_imem_resp_bits_err,
   input  logic                     io_imem_resp_ready,
   input  logic                     flush,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [31:0]              prog_data,
   output logic [3:0]               outstanding
);

   localparam int              c_AW    = $clog2(DEPTH);
   localparam int              c_QW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [3:0]      c_MAX   = 4'(MAX_OUTSTANDING);
   localparam logic [c_QW-1:0] c_QLAST = c_QW'(MAX_OUTSTANDING - 1);

   logic [31:0]     r_mem [DEPTH];
   logic [3:0]      r_outstanding;
   logic [31:0]     r_qd [MAX_OUTSTANDING];
   logic            r_qe [MAX_OUTSTANDING];
   logic [c_QW-1:0] r_rd;
   logic [c_QW-1:0] r_wr;
   logic [3:0]      r_qcnt;

   logic            w_req_fire;
   logic            w_resp_fire;
   logic [c_AW-1:0] w_idx;
   logic            w_lookup_err;
   logic [31:0]     w_lookup_data;
   logic            w_push;
   logic [31:0]     w_push_data;
   logic            w_push_err;

   function automatic logic [c_QW-1:0] next_ptr(input logic [c_QW-1:0] p);
      return (p == c_QLAST) ? '0 : p + 1'b1;
   endfunction

   // Program store; writes land even during a flush cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= NOP_INST;
         end
      end else if (prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   assign io_imem_req_ready = reset && (r_outstanding < c_MAX) && !flush;
   assign io_imem_resp_valid = (r_qcnt != 4'd0) && !flush;
   assign w_req_fire  = io_imem_req_valid && io_imem_req_ready;
   assign w_resp_fire = io_imem_resp_valid && io_imem_resp_ready;

   // Snapshot taken before this edge's write, so same-cycle writes return old data
   assign w_idx         = io_imem_req_bits_addr[c_AW+1:2];
   assign w_lookup_err  = (io_imem_req_bits_addr[1:0] != 2'b00) ||
                          ((io_imem_req_bits_addr >> (c_AW + 2)) != 32'd0);
   assign w_lookup_data = w_lookup_err ? NOP_INST : r_mem[w_idx];

   generate
      if (LATENCY == 1) begin : g_direct
         assign w_push      = w_req_fire;
         assign w_push_data = w_lookup_data;
         assign w_push_err  = w_lookup_err;
      end else begin : g_pipe
         localparam int c_STAGES = LATENCY - 1;
         logic [c_STAGES-1:0] r_pv;
         logic [c_STAGES-1:0] r_pe;
         logic [31:0]         r_pd [c_STAGES];

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               r_pv <= '0;
               r_pe <= '0;
               for (int i = 0; i < c_STAGES; i++) begin
                  r_pd[i] <= NOP_INST;
               end
            end else if (flush) begin
               r_pv <= '0;
            end else begin
               r_pv[0] <= w_req_fire;
               r_pd[0] <= w_lookup_data;
               r_pe[0] <= w_lookup_err;
               for (int i = 1; i < c_STAGES; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pd[i] <= r_pd[i-1];
                  r_pe[i] <= r_pe[i-1];
               end
            end
         end

         assign w_push      = r_pv[c_STAGES-1];
         assign w_push_data = r_pd[c_STAGES-1];
         assign w_push_err  = r_pe[c_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_qd[r_wr] <= w_push_data;
         r_qe[r_wr] <= w_push_err;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_qcnt <= 4'd0;
      end else if (flush) begin
         r_rd   <= '0;
         r_wr   <= '0;
         r_qcnt <= 4'd0;
      end else begin
         if (w_push) begin
            r_wr <= next_ptr(r_wr);
         end
         if (w_resp_fire) begin
            r_rd <= next_ptr(r_rd);
         end
         case ({w_push, w_resp_fire})
            2'b10:   r_qcnt <= r_qcnt + 4'd1;
            2'b01:   r_qcnt <= r_qcnt - 4'd1;
            default: r_qcnt <= r_qcnt;
         endcase
      end
   end

   assign io_imem_resp_bits_data = (r_qcnt != 4'd0) ? r_qd[r_rd] : NOP_INST;
   assign io_imem_resp_bits_err  = (r_qcnt != 4'd0) ? r_qe[r_rd] : 1'b0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_outstanding <= 4'd0;
      end else if (flush) begin
         r_outstanding <= 4'd0;
      end else begin
         case ({w_req_fire, w_resp_fire})
            2'b10:   r_outstanding <= r_outstanding + 4'd1;
            2'b01:   r_outstanding <= r_outstanding - 4'd1;
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_sodor_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sodor_imem_responder
// Desc     : Randomized and directed bench for sodor_imem_responder against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sodor_imem_responder;

   localparam int          DEPTH = 16;
   localparam int          LAT   = 2;
   localparam int          MAXO  = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        resp_ready;
   logic        flush;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [31:0] prog_data;
   logic [3:0]  outstanding;

   sodor_imem_responder #(
      .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .NOP_INST(NOP)
   ) dut (
      .clock(clock), .reset(reset),
      .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
      .io_imem_req_ready(req_ready),
      .io_imem_resp_valid(resp_valid), .io_imem_resp_bits_data(resp_data),
      .io_imem_resp_bits_err(resp_err), .io_imem_resp_ready(resp_ready),
      .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .outstanding(outstanding)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      int          rdy;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mm [DEPTH];
   int          now = 0;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, now);
      end
   endfunction

   // Checks outputs against the model, then advances the model across one edge
   task automatic cycle();
      logic        vis, e_ready, e_valid, fire_req, fire_resp, a_err;
      logic [31:0] e_data, a_data;
      logic        e_err;
      #1;
      if (!reset) begin
         mq.delete();
         for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
      end
      vis     = (mq.size() != 0) && (mq[0].rdy <= now);
      e_ready = reset && (mq.size() < MAXO) && !flush;
      e_valid = vis && !flush;
      e_data  = vis ? mq[0].data : NOP;
      e_err   = vis ? mq[0].err : 1'b0;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("resp_valid", 32'(resp_valid), 32'(e_valid));
      chk("outstanding", 32'(outstanding), mq.size());
      if (!(flush && vis)) begin
         chk("resp_data", resp_data, e_data);
         chk("resp_err", 32'(resp_err), 32'(e_err));
      end
      fire_req  = e_ready && req_valid;
      fire_resp = e_valid && resp_ready;
      a_err  = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
      a_data = a_err ? NOP : mm[req_addr[5:2]];
      @(posedge clock);
      if (reset) begin
         if (flush) mq.delete();
         else begin
            if (fire_resp) void'(mq.pop_front());
            if (fire_req) mq.push_back('{data: a_data, err: a_err, rdy: now + LAT});
         end
         if (prog_we) mm[prog_addr] = prog_data;
      end
      now++;
      @(negedge clock);
   endtask

   task automatic drv(input logic v, input logic [31:0] a, input logic rr, input logic fl);
      req_valid  = v;
      req_addr   = a;
      resp_ready = rr;
      flush      = fl;
      prog_we    = 1'b0;
   endtask

   task automatic prog(input logic [3:0] wa, input logic [31:0] wd);
      prog_we   = 1'b1;
      prog_addr = wa;
      prog_data = wd;
   endtask

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0);
      prog_addr = 4'd0;
      prog_data = 32'd0;
      for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
      #2 reset = 1'b0;
      @(negedge clock);

      repeat (3) begin
         #1;
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_data", resp_data, NOP);
         chk("rst_out", 32'(outstanding), 32'd0);
         cycle();
      end
      reset = 1'b1;
      #1 chk("rel_ready", 32'(req_ready), 32'd1);

      // Single fetch with LATENCY=2
      drv(0, 0, 1, 0); prog(4'd1, 32'h06400083); cycle();
      drv(1, 32'h4, 1, 0); cycle();
      drv(0, 0, 1, 0); #1 chk("t1_early", 32'(resp_valid), 32'd0); cycle();
      #1;
      chk("t1_valid", 32'(resp_valid), 32'd1);
      chk("t1_data", resp_data, 32'h06400083);
      chk("t1_err", 32'(resp_err), 32'd0);
      chk("t1_out1", 32'(outstanding), 32'd1);
      cycle();
      #1 chk("t1_out0", 32'(outstanding), 32'd0); cycle();

      // Fill to MAX_OUTSTANDING, then drain in order
      drv(0, 0, 0, 0); prog(4'd2, 32'h00A00113); cycle();
      drv(0, 0, 0, 0); prog(4'd3, 32'h00B00193); cycle();
      for (int i = 0; i < 4; i++) begin drv(1, 32'(i * 4), 0, 0); cycle(); end
      drv(0, 0, 0, 0);
      #1 chk("t2_full_ready", 32'(req_ready), 32'd0);
      chk("t2_full_out", 32'(outstanding), 32'd4);
      cycle(); cycle(); cycle();
      drv(0, 0, 1, 0);
      #1 chk("t2_r0", resp_data, 32'h00000013);
      chk("t2_r0_ready", 32'(req_ready), 32'd0);
      cycle();
      #1 chk("t2_r1", resp_data, 32'h06400083);
      chk("t2_r1_ready", 32'(req_ready), 32'd1);
      chk("t2_r1_out", 32'(outstanding), 32'd3);
      cycle();
      #1 chk("t2_r2", resp_data, 32'h00A00113); cycle();
      #1 chk("t2_r3", resp_data, 32'h00B00193); cycle();
      #1 chk("t2_empty", 32'(resp_valid), 32'd0); cycle();

      // Out-of-range and misaligned
      drv(1, 32'h40, 1, 0); cycle();
      drv(1, 32'h6, 1, 0); cycle();
      drv(0, 0, 1, 0);
      #1 chk("t3_oor_err", 32'(resp_err), 32'd1);
      chk("t3_oor_data", resp_data, NOP);
      cycle();
      #1 chk("t3_mis_err", 32'(resp_err), 32'd1);
      chk("t3_mis_data", resp_data, NOP);
      cycle();

      // Flush with three outstanding
      for (int i = 0; i < 3; i++) begin drv(1, 32'(i * 4), 0, 0); cycle(); end
      drv(0, 0, 0, 0); cycle();
      drv(0, 0, 1, 1);
      #1 chk("t4_fl_valid", 32'(resp_valid), 32'd0);
      chk("t4_fl_ready", 32'(req_ready), 32'd0);
      cycle();
      drv(1, 32'h8, 1, 0);
      #1 chk("t4_out", 32'(outstanding), 32'd0);
      chk("t4_ready", 32'(req_ready), 32'd1);
      cycle();
      drv(0, 0, 1, 0); cycle();
      #1 chk("t4_data", resp_data, 32'h00A00113); cycle();

      // Same-cycle write and fetch
      drv(1, 32'h8, 1, 0); prog(4'd2, 32'hDEADBEEF); cycle();
      drv(1, 32'h8, 1, 0); cycle();
      drv(0, 0, 1, 0);
      #1 chk("t5_old", resp_data, 32'h00A00113); cycle();
      #1 chk("t5_new", resp_data, 32'hDEADBEEF); cycle();

      // Async reset with queued responses
      drv(1, 32'h0, 0, 0); cycle();
      drv(1, 32'h4, 0, 0); cycle();
      drv(0, 0, 0, 0); cycle(); cycle();
      #1 chk("t6_pre_valid", 32'(resp_valid), 32'd1);
      reset = 1'b0;
      #1 chk("t6_rst_valid", 32'(resp_valid), 32'd0);
      chk("t6_rst_out", 32'(outstanding), 32'd0);
      cycle(); cycle();
      reset = 1'b1;
      #1 chk("t6_rel_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin drv(1, 32'(i * 4), 1, 0); cycle(); end
      drv(0, 0, 1, 0); cycle(); cycle(); cycle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            default: a = 32'($urandom_range(0, 15)) << 2;
         endcase
         drv($urandom_range(0, 99) < 60, a, $urandom_range(0, 99) < 65,
             $urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 20) prog(4'($urandom_range(0, 15)), $urandom);
         reset = ($urandom_range(0, 999) < 4) ? 1'b0 : 1'b1;
         cycle();
      end
      reset = 1'b1;
      drv(0, 0, 1, 0);
      repeat (10) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
